// File: rtl/aes_pkg.sv
// Shared AES scheduler types and constants.
package aes_pkg;

    localparam int AES_BLK = 128;

    // Number of cipher rounds for key-size select x (0/1/2 -> 128/192/256).
    function automatic int nr(input int x);
        return 10 + 2 * x;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        RESP
    } state_t;

endpackage

// File: rtl/aes_cipher_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [IDW-1:0]  grant,
    output logic            any_req
);

    // Scan NREQ positions starting one past the previous winner; first hit wins.
    always_comb begin
        logic found;
        int   idx;
        grant   = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_grant) + k) % NREQ;
            if (!found && req[idx]) begin
                grant = IDW'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_cipher_scheduler.sv
// Time-shares one iterative AES core between NREQ requesters: round-robin
// grant, clear the core, run it NR+1 cycles, return the ciphertext tagged
// with the owner's index on a single valid/ready response port.
module aes_cipher_scheduler
    import aes_pkg::*;
#(
    parameter int X    = 0,
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*AES_BLK-1:0] req_data,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [AES_BLK-1:0]      resp_data,
    output logic [IDW-1:0]          resp_id,
    output logic                    core_clear,
    output logic                    core_enable,
    output logic [AES_BLK-1:0]      core_in,
    input  logic [AES_BLK-1:0]      core_out,
    output logic                    busy
);

    localparam int NRV = nr(X);
    localparam int CW  = $clog2(NRV + 1);

    state_t             state, state_d;
    logic [CW-1:0]      cnt;
    logic [AES_BLK-1:0] blk_q;
    logic [IDW-1:0]     id_q;
    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     grant;
    logic               any_req;
    logic               take;
    logic               capture;

    rr_arbiter #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_arb (
        .req       (req_valid),
        .last_grant(last_grant),
        .grant     (grant),
        .any_req   (any_req)
    );

    // The core sees the latched block in every state, so it is stable through CLEAR and RUN.
    assign core_in = blk_q;
    assign busy    = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state and control strobes; req_ready is masked while rst is high so
    // every output reads zero during reset.
    always_comb begin
        state_d     = state;
        req_ready   = '0;
        core_clear  = 1'b0;
        core_enable = 1'b0;
        resp_valid  = 1'b0;
        take        = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req && !rst) begin
                    req_ready[grant] = 1'b1;
                    take             = 1'b1;
                    state_d          = CLEAR;
                end
            end
            CLEAR: begin
                core_clear = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                core_enable = 1'b1;
                if (cnt == CW'(NRV)) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the granted block, count core rounds, capture the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_q      <= '0;
            id_q       <= '0;
            last_grant <= IDW'(NREQ - 1);
            cnt        <= '0;
            resp_data  <= '0;
            resp_id    <= '0;
        end else begin
            if (take) begin
                blk_q      <= req_data[grant*AES_BLK +: AES_BLK];
                id_q       <= grant;
                last_grant <= grant;
            end
            if (state == CLEAR)
                cnt <= '0;
            else if (state == RUN && cnt != CW'(NRV))
                cnt <= cnt + 1'b1;
            if (capture) begin
                resp_data <= core_out;
                resp_id   <= id_q;
            end
        end
    end

endmodule
